fd_uart: RTL and testbench

//  Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock/reset.
//  TX serialises a byte on Tx_start; RX deserialises, checks framing, reports rx_data.

---
 rtl/fd_uart.sv | 238 +++++++++++++++++++++++
 tb/tb_fd_uart.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fd_uart.sv
// fd_uart: full-duplex 8N1 UART with independent TX and RX state machines.
// Optional feature: define UART_PARITY_EN to add an even-parity bit after
// data bit 7 (11-bit frame); RX then flags parity mismatch as well as a
// bad stop bit on error_flag.
module fd_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_start,
  input  logic [7:0] data_in,
  input  logic       rx_serial_in,
  output logic       tx_serial_out,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       error_flag
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t          tx_state_r;
  logic [CW-1:0]   tx_cnt_r;
  logic [2:0]      tx_bit_r;
  logic [7:0]      tx_shift_r;
`ifdef UART_PARITY_EN
  logic            tx_par_r;
  logic            rx_par_err_r;
`endif

  state_t          rx_state_r;
  logic [CW-1:0]   rx_cnt_r;
  logic [2:0]      rx_bit_r;
  logic [7:0]      rx_shift_r;
  logic            rx_meta_r;
  logic            rx_sync_r;

  // Transmitter: serialise the latched byte, one bit per CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r    <= ST_IDLE;
      tx_cnt_r      <= '0;
      tx_bit_r      <= 3'd0;
      tx_shift_r    <= 8'h00;
      tx_serial_out <= 1'b1;
      tx_done       <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_r      <= 1'b0;
`endif
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          if (Tx_start) begin
            tx_shift_r    <= data_in;
`ifdef UART_PARITY_EN
            tx_par_r      <= even_parity(data_in);
`endif
            tx_done       <= 1'b0;
            tx_serial_out <= 1'b0;
            tx_cnt_r      <= '0;
            tx_state_r    <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r      <= '0;
            tx_bit_r      <= 3'd0;
            tx_serial_out <= tx_shift_r[0];
            tx_state_r    <= ST_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r <= '0;
            if (tx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_serial_out <= tx_par_r;
              tx_state_r    <= ST_PARITY;
`else
              tx_serial_out <= 1'b1;
              tx_state_r    <= ST_STOP;
`endif
            end else begin
              tx_bit_r      <= tx_bit_r + 3'd1;
              tx_shift_r    <= {1'b0, tx_shift_r[7:1]};
              tx_serial_out <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r      <= '0;
            tx_serial_out <= 1'b1;
            tx_state_r    <= ST_STOP;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r   <= '0;
            tx_done    <= 1'b1;
            tx_state_r <= ST_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        default: begin
          tx_cnt_r      <= '0;
          tx_serial_out <= 1'b1;
          tx_state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_serial_in;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver: confirm start at half-bit, then sample every bit at its centre.
  // rx_done is only cleared once a start bit is confirmed, so a short low
  // glitch on an idle line leaves all outputs untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r   <= ST_IDLE;
      rx_cnt_r     <= '0;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= 8'h00;
      rx_data      <= 8'h00;
      rx_done      <= 1'b0;
      error_flag   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_err_r <= 1'b0;
`endif
    end else begin
      case (rx_state_r)
        ST_IDLE: begin
          rx_cnt_r <= '0;
          if (!rx_sync_r) begin
            rx_state_r <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r <= '0;
            if (!rx_sync_r) begin
              rx_done    <= 1'b0;
              rx_bit_r   <= 3'd0;
              rx_state_r <= ST_DATA;
            end else begin
              rx_state_r <= ST_IDLE;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state_r <= ST_PARITY;
`else
              rx_state_r <= ST_STOP;
`endif
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r     <= '0;
            rx_par_err_r <= rx_sync_r ^ even_parity(rx_shift_r);
            rx_state_r   <= ST_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= '0;
            rx_data    <= rx_shift_r;
            rx_done    <= 1'b1;
`ifdef UART_PARITY_EN
            error_flag <= ~rx_sync_r | rx_par_err_r;
`else
            error_flag <= ~rx_sync_r;
`endif
            rx_state_r <= ST_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        default: begin
          rx_cnt_r   <= '0;
          rx_state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fd_uart.sv
// tb_fd_uart: self-checking bench for fd_uart (CLKS_PER_BIT = 16).
// Expected line waveforms and receiver results come from a frame-level
// model: a frame is the concatenation start/data/[parity]/stop bits.
module tb_fd_uart;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rx_drive = 1'b1;
  logic       loop_en = 1'b1;
  logic       rx_serial_in;
  logic       tx_serial_out;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       error_flag;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx_data = 8'h00;
  logic       exp_err = 1'b0;

  assign rx_serial_in = loop_en ? tx_serial_out : rx_drive;

  fd_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .Tx_start(Tx_start), .data_in(data_in),
    .rx_serial_in(rx_serial_in), .tx_serial_out(tx_serial_out),
    .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done),
    .error_flag(error_flag)
  );

  always #5 clk = ~clk;

  // Line bits in transmission order: element 0 is the start bit.
  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b, input logic stop);
`ifdef UART_PARITY_EN
    return {stop, ^b, b, 1'b0};
`else
    return {stop, b, 1'b0};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    check1({tag, "_rx_done"}, rx_done, 1'b1);
    check8({tag, "_rx_data"}, rx_data, exp_rx_data);
    check1({tag, "_error"}, error_flag, exp_err);
  endtask

  // Loopback transfer of one byte; optionally pokes Tx_start mid-frame.
  task automatic send_and_check(input logic [7:0] b, input bit poke_busy, input string tag);
    logic [NBITS-1:0] f;
    f = frame_bits(b, 1'b1);
    loop_en  = 1'b1;
    Tx_start = 1'b1;
    data_in  = b;
    tick(1);
    Tx_start = 1'b0;
    data_in  = ~b;
    check1({tag, "_tx_done_clr"}, tx_done, 1'b0);
    for (int k = 0; k < NBITS; k++) begin
      tick(CPB / 2);
      check1($sformatf("%s_bit%0d", tag, k), tx_serial_out, f[k]);
      if (k == 1) check1({tag, "_rx_done_clr"}, rx_done, 1'b0);
      if (poke_busy && k == 4) begin
        Tx_start = 1'b1;
        data_in  = 8'h0F;
        tick(1);
        Tx_start = 1'b0;
        tick(CPB / 2 - 1);
      end else begin
        tick(CPB / 2);
      end
    end
    exp_rx_data = b;
    exp_err     = 1'b0;
    check1({tag, "_tx_done"}, tx_done, 1'b1);
    check1({tag, "_line_idle"}, tx_serial_out, 1'b1);
    check_rx(tag);
    if (poke_busy) begin
      for (int c = 0; c < 2 * CPB; c++) begin
        tick(1);
        if (tx_serial_out !== 1'b1) break;
      end
      check1({tag, "_no_queued_frame"}, tx_serial_out, 1'b1);
      check1({tag, "_tx_done_hold"}, tx_done, 1'b1);
    end
  endtask

  // Drive a frame directly onto the RX input with a chosen stop-bit value.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input string tag);
    logic [NBITS-1:0] f;
    f = frame_bits(b, stop);
    loop_en = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      rx_drive = f[k];
      tick(CPB);
    end
    rx_drive = 1'b1;
    tick(2 * CPB);
    exp_rx_data = b;
    exp_err     = ~stop;
    check_rx(tag);
  endtask

  initial begin
    logic [7:0] b;

    // Reset held for three cycles.
    tick(3);
    check1("rst_line", tx_serial_out, 1'b1);
    check1("rst_tx_done", tx_done, 1'b0);
    check1("rst_rx_done", rx_done, 1'b0);
    check8("rst_rx_data", rx_data, 8'h00);
    check1("rst_error", error_flag, 1'b0);
    reset = 1'b0;
    tick(2);

    send_and_check(8'h55, 1'b0, "t55");
    send_and_check(8'hA3, 1'b1, "tA3");

    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_and_check(b, 1'b0, $sformatf("rnd%0d", i));
    end

    drive_frame(8'h3C, 1'b0, "bad_stop");
    b = 8'($urandom_range(0, 255));
    drive_frame(b, 1'b1, "direct_ok");

    // Short low glitch on an idle line must not disturb the receiver.
    rx_drive = 1'b0;
    tick(3);
    rx_drive = 1'b1;
    tick(2 * CPB);
    check_rx("glitch");

    // Reset in the middle of a loopback frame.
    loop_en  = 1'b1;
    Tx_start = 1'b1;
    data_in  = 8'($urandom_range(0, 255));
    tick(1);
    Tx_start = 1'b0;
    tick(40);
    reset = 1'b1;
    tick(1);
    check1("midrst_line", tx_serial_out, 1'b1);
    check1("midrst_tx_done", tx_done, 1'b0);
    check1("midrst_rx_done", rx_done, 1'b0);
    check8("midrst_rx_data", rx_data, 8'h00);
    check1("midrst_error", error_flag, 1'b0);
    reset = 1'b0;
    tick(2);
    b = 8'($urandom_range(0, 255));
    send_and_check(b, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
